// File: rtl/tour_sequencer_pkg.sv
// Shared constants and types for the knight's-tour command sequencer.
// Holds the UART command opcodes, compass headings, response bytes and FSM state type.
// Imported by tour_sequencer and move_decode; contains no logic.
package tour_sequencer_pkg;

  // Command word layout: [15:12] opcode, [11:4] heading, [3:0] square count
  localparam logic [3:0] OPC_MOVE    = 4'h2;
  localparam logic [3:0] OPC_FANFARE = 4'h3;

  // Headings: +y is north, +x is east
  localparam logic [7:0] HDG_NORTH = 8'h00;
  localparam logic [7:0] HDG_WEST  = 8'h3F;
  localparam logic [7:0] HDG_SOUTH = 8'h7F;
  localparam logic [7:0] HDG_EAST  = 8'hBF;

  localparam logic [7:0] RESP_BUSY = 8'hA5;
  localparam logic [7:0] RESP_DONE = 8'h5A;

  localparam logic [4:0] LAST_MV_INDX = 5'd23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VERT,
    ST_VERT_ACK,
    ST_HORZ,
    ST_HORZ_ACK
  } state_t;

endpackage

// File: rtl/tour_sequencer_move_decode.sv
// Decodes a one-hot knight move into vertical and horizontal leg counts and headings.
// Latency: purely combinational. Backpressure: none.
// Ports: move (one-hot) in; dx_sq/dy_sq square counts and horz_hdg/vert_hdg headings out.
module move_decode
  import tour_sequencer_pkg::*;
(
  input  logic [7:0] move,
  output logic [3:0] dx_sq,
  output logic [3:0] dy_sq,
  output logic [7:0] vert_hdg,
  output logic [7:0] horz_hdg
);

  always_comb begin
    // Anything not exactly one-hot is an illegal move: zero-length legs, so the
    // robot stays put while the sequence still advances.
    dx_sq    = 4'd0;
    dy_sq    = 4'd0;
    vert_hdg = HDG_NORTH;
    horz_hdg = HDG_EAST;
    case (move)
      8'h01: begin dx_sq = 4'd1; horz_hdg = HDG_EAST; dy_sq = 4'd2; vert_hdg = HDG_NORTH; end
      8'h02: begin dx_sq = 4'd1; horz_hdg = HDG_WEST; dy_sq = 4'd2; vert_hdg = HDG_NORTH; end
      8'h04: begin dx_sq = 4'd2; horz_hdg = HDG_WEST; dy_sq = 4'd1; vert_hdg = HDG_NORTH; end
      8'h08: begin dx_sq = 4'd2; horz_hdg = HDG_WEST; dy_sq = 4'd1; vert_hdg = HDG_SOUTH; end
      8'h10: begin dx_sq = 4'd1; horz_hdg = HDG_WEST; dy_sq = 4'd2; vert_hdg = HDG_SOUTH; end
      8'h20: begin dx_sq = 4'd1; horz_hdg = HDG_EAST; dy_sq = 4'd2; vert_hdg = HDG_SOUTH; end
      8'h40: begin dx_sq = 4'd2; horz_hdg = HDG_EAST; dy_sq = 4'd1; vert_hdg = HDG_SOUTH; end
      8'h80: begin dx_sq = 4'd2; horz_hdg = HDG_EAST; dy_sq = 4'd1; vert_hdg = HDG_NORTH; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tour_sequencer.sv
// Plays a solved 24-move knight's tour to the command processor, or passes UART commands through when idle.
// Latency: cmd/cmd_rdy/resp are combinational from state, move and mv_indx; one state register only.
// Backpressure: each leg is held with cmd_rdy=1 until clr_cmd_rdy, then waits for send_resp before the next leg.
// Ports: start_tour/move/mv_indx to the solver; cmd_UART/cmd_rdy_UART from the UART wrapper;
//        clr_cmd_rdy/send_resp from the command processor; cmd/cmd_rdy/resp muxed outputs.
module tour_sequencer
  import tour_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp
);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] mv_indx_nxt;

  logic [3:0] dx_sq;
  logic [3:0] dy_sq;
  logic [7:0] vert_hdg;
  logic [7:0] horz_hdg;
  logic       last_move;

  move_decode u_move_decode (
    .move     (move),
    .dx_sq    (dx_sq),
    .dy_sq    (dy_sq),
    .vert_hdg (vert_hdg),
    .horz_hdg (horz_hdg)
  );

  assign last_move = (mv_indx == LAST_MV_INDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      mv_indx <= 5'd0;
    end else begin
      state   <= state_nxt;
      mv_indx <= mv_indx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mv_indx_nxt = mv_indx;
    cmd         = cmd_UART;
    cmd_rdy     = cmd_rdy_UART;
    resp        = RESP_DONE;
    case (state)
      ST_IDLE: begin
        mv_indx_nxt = 5'd0;
        if (start_tour) state_nxt = ST_VERT;
      end
      ST_VERT: begin
        cmd     = {OPC_MOVE, vert_hdg, dy_sq};
        cmd_rdy = 1'b1;
        resp    = RESP_BUSY;
        // clr_cmd_rdy wins; a coincident send_resp belongs to the previous command
        if (clr_cmd_rdy) state_nxt = ST_VERT_ACK;
      end
      ST_VERT_ACK: begin
        cmd     = {OPC_MOVE, vert_hdg, dy_sq};
        cmd_rdy = 1'b0;
        resp    = RESP_BUSY;
        if (send_resp) state_nxt = ST_HORZ;
      end
      ST_HORZ: begin
        cmd     = {OPC_FANFARE, horz_hdg, dx_sq};
        cmd_rdy = 1'b1;
        resp    = RESP_BUSY;
        if (clr_cmd_rdy) state_nxt = ST_HORZ_ACK;
      end
      ST_HORZ_ACK: begin
        cmd     = {OPC_FANFARE, horz_hdg, dx_sq};
        cmd_rdy = 1'b0;
        // The final leg's response goes back as a normal UART response
        resp    = last_move ? RESP_DONE : RESP_BUSY;
        if (send_resp) begin
          if (last_move) begin
            state_nxt   = ST_IDLE;
            mv_indx_nxt = 5'd0;
          end else begin
            state_nxt   = ST_VERT;
            mv_indx_nxt = mv_indx + 5'd1;
          end
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        mv_indx_nxt = 5'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_tour_sequencer.sv
// Self-checking bench for tour_sequencer: a step-count model of the tour plus directed literal checks.
// Latency: n/a. Backpressure: the bench plays the command processor, acknowledging legs directly or randomly.
// Ports: none.
module tb_tour_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  always #5 clk = ~clk;

  tour_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .resp         (resp)
  );

  // Solver model: the solution table read at the index the DUT drives
  logic [7:0] tour_mem [24];
  assign move = (mv_indx < 5'd24) ? tour_mem[mv_indx] : 8'h00;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Knight displacement per one-hot bit
  localparam int DXS [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  localparam int DYS [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  function automatic logic [15:0] leg(input logic [7:0] m, input bit horz);
    int b;
    int d;
    int a;
    logic [7:0] hdg;
    b = -1;
    for (int i = 0; i < 8; i++) if (m == (8'h01 << i)) b = i;
    if (b < 0) return horz ? 16'h3000 : 16'h2000;
    d   = horz ? DXS[b] : DYS[b];
    a   = (d < 0) ? -d : d;
    if (horz) hdg = (d > 0) ? 8'hBF : 8'h3F;
    else      hdg = (d > 0) ? 8'h00 : 8'h7F;
    return {(horz ? 4'h3 : 4'h2), hdg, a[3:0]};
  endfunction

  // Tour model: 96 steps, four per move (vert issued, vert acked, horz issued, horz acked)
  bit m_active;
  int m_k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
    end else if (!m_active) begin
      if (start_tour) begin
        m_active <= 1'b1;
        m_k      <= 0;
      end
    end else if (m_k % 2 == 0) begin
      if (clr_cmd_rdy) m_k <= m_k + 1;
    end else if (send_resp) begin
      if (m_k == 95) begin
        m_active <= 1'b0;
        m_k      <= 0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  bit counting = 1'b0;
  int rdy_cnt  = 0;

  // Single compare process: DUT outputs against the model every cycle
  always @(negedge clk) begin
    logic [15:0] exp_cmd;
    logic [15:0] mask;
    logic        exp_rdy;
    logic [4:0]  exp_idx;
    logic [7:0]  exp_resp;
    int          i;
    int          ph;
    if (!m_active) begin
      exp_cmd  = cmd_UART;
      mask     = 16'hFFFF;
      exp_rdy  = cmd_rdy_UART;
      exp_idx  = 5'd0;
      exp_resp = 8'h5A;
    end else begin
      i        = m_k / 4;
      ph       = m_k % 4;
      exp_idx  = 5'(i);
      exp_rdy  = (ph == 0) || (ph == 2);
      exp_resp = (m_k == 95) ? 8'h5A : 8'hA5;
      exp_cmd  = leg(tour_mem[i], ph >= 2);
      mask     = $onehot(tour_mem[i]) ? 16'hFFFF : 16'hF00F;
    end
    check("cmd_rdy", cmd_rdy, exp_rdy);
    check("mv_indx", mv_indx, exp_idx);
    check("resp", resp, exp_resp);
    if (exp_rdy || !m_active) check("cmd", cmd & mask, exp_cmd & mask);
    if (counting && cmd_rdy) rdy_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
  endtask

  // Acknowledge every leg immediately until the model reaches step target (or the tour ends)
  task automatic ack_until(input int target, input string name);
    int budget;
    budget = 400;
    while (m_active && m_k != target && budget > 0) begin
      clr_cmd_rdy = (m_k % 2 == 0);
      send_resp   = (m_k % 2 == 1);
      step();
      budget--;
    end
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    check({name, "_bound"}, (budget > 0), 1'b1);
  endtask

  task automatic rand_tour();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 9) == 0) tour_mem[i] = 8'($urandom);
      else                           tour_mem[i] = 8'h01 << $urandom_range(0, 7);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start_tour   = 1'b0;
    cmd_UART     = 16'h0000;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    rand_tour();
    #1;
    check("rst_mv_indx", mv_indx, 5'd0);
    check("rst_resp", resp, 8'h5A);
    check("rst_cmd_rdy", cmd_rdy, 1'b1);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // IDLE pass-through
    cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1;
    #1;
    check("pass_cmd", cmd, 16'h2003);
    check("pass_rdy", cmd_rdy, 1'b1);
    check("pass_resp", resp, 8'h5A);
    cmd_rdy_UART = 1'b0;
    step();

    // Directed legs for moves 8'h01 and 8'h08
    tour_mem[0] = 8'h01;
    tour_mem[1] = 8'h08;
    tour_mem[2] = 8'h40;
    pulse_start();
    check("m01_vert", cmd, 16'h2002);
    cmd_rdy_UART = 1'b1;
    step(); step();
    check("m01_vert_hold", cmd, 16'h2002);
    check("m01_vert_rdy", cmd_rdy, 1'b1);
    cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
    check("vack_rdy", cmd_rdy, 1'b0);
    check("vack_resp", resp, 8'hA5);
    send_resp = 1'b1; step(); send_resp = 1'b0;
    check("m01_horz", cmd, 16'h3BF1);
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
    send_resp = 1'b1; step(); send_resp = 1'b0;
    check("m08_vert", cmd, 16'h27F1);
    check("m08_idx", mv_indx, 5'd1);
    clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
    send_resp = 1'b1; step(); send_resp = 1'b0;
    check("m08_horz", cmd, 16'h33F2);

    // start_tour in VERT (index 2) has no effect
    ack_until(8, "to_idx2");
    pulse_start();
    step();
    check("start_ign_idx", mv_indx, 5'd2);
    check("start_ign_rdy", cmd_rdy, 1'b1);

    // clr and send together in VERT: only the clr transition
    clr_cmd_rdy = 1'b1; send_resp = 1'b1; step();
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; step();
    check("both_vack_rdy", cmd_rdy, 1'b0);
    check("both_vack_idx", mv_indx, 5'd2);
    ack_until(-1, "finish1");

    // Full run with immediate acks: 48 leg assertions
    rand_tour();
    cmd_rdy_UART = 1'b0;
    rdy_cnt  = 0;
    counting = 1'b1;
    pulse_start();
    ack_until(95, "to_final");
    check("final_resp", resp, 8'h5A);
    check("final_idx", mv_indx, 5'd23);
    ack_until(-1, "finish2");
    step();
    counting = 1'b0;
    check("rdy_count", rdy_cnt, 48);
    check("final_idle_resp", resp, 8'h5A);

    // Reset in HORZ_ACK of move 7
    pulse_start();
    ack_until(31, "to_idx7");
    check("pre_rst_idx", mv_indx, 5'd7);
    check("pre_rst_rdy", cmd_rdy, 1'b0);
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_idx", mv_indx, 5'd0);
    check("midrst_cmd", cmd, 16'h1234);
    check("midrst_rdy", cmd_rdy, 1'b1);
    check("midrst_resp", resp, 8'h5A);
    step();
    rst_n = 1'b1;
    cmd_rdy_UART = 1'b0;
    send_resp = 1'b1; clr_cmd_rdy = 1'b1;
    step(); step();
    send_resp = 1'b0; clr_cmd_rdy = 1'b0;
    check("postrst_idx", mv_indx, 5'd0);
    check("postrst_rdy", cmd_rdy, 1'b0);

    // Randomized tours with random handshakes, UART traffic and stray start pulses
    for (int t = 0; t < 6; t++) begin
      int budget;
      rand_tour();
      repeat ($urandom_range(3, 8)) begin
        cmd_UART     = 16'($urandom);
        cmd_rdy_UART = 1'($urandom);
        step();
      end
      pulse_start();
      budget = 3000;
      while (m_active && budget > 0) begin
        clr_cmd_rdy  = ($urandom_range(0, 2) == 0);
        send_resp    = ($urandom_range(0, 2) == 0);
        start_tour   = ($urandom_range(0, 15) == 0);
        cmd_UART     = 16'($urandom);
        cmd_rdy_UART = 1'($urandom);
        step();
        budget--;
      end
      clr_cmd_rdy = 1'b0;
      send_resp   = 1'b0;
      start_tour  = 1'b0;
      check("rand_tour_done", (budget > 0), 1'b1);
      step();
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
